// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with level count, almost-full/empty flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read.
module sync_fifo_param #(
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_DAT_WD  = 4,
  parameter int FIFO_ADDR_WD = 3,
  parameter int AFULL_THR    = 6,
  parameter int AEMPTY_THR   = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr_i,
  input  logic                    wr_en_i,
  input  logic [FIFO_DAT_WD-1:0]  wr_dat_i,
  output logic                    wr_full_o,
  output logic                    wr_afull_o,
  input  logic                    rd_en_i,
  output logic [FIFO_DAT_WD-1:0]  rd_dat_o,
  output logic                    rd_empty_o,
  output logic                    rd_aempty_o,
  output logic [FIFO_ADDR_WD:0]   level_o,
  output logic                    ovf_o,
  output logic                    udf_o
);

  localparam int LVL_WD = FIFO_ADDR_WD + 1;
  localparam logic [LVL_WD-1:0]       DEPTH_LVL  = LVL_WD'(FIFO_DEPTH);
  localparam logic [LVL_WD-1:0]       AFULL_LVL  = LVL_WD'(AFULL_THR);
  localparam logic [LVL_WD-1:0]       AEMPTY_LVL = LVL_WD'(AEMPTY_THR);
  localparam logic [LVL_WD-1:0]       LVL_ONE    = LVL_WD'(1);
  localparam logic [FIFO_ADDR_WD-1:0] PTR_LAST   = FIFO_ADDR_WD'(FIFO_DEPTH - 1);
  localparam logic [FIFO_ADDR_WD-1:0] PTR_ONE    = FIFO_ADDR_WD'(1);

  logic [FIFO_DAT_WD-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WD-1:0] wr_ptr;
  logic [FIFO_ADDR_WD-1:0] rd_ptr;
  logic [LVL_WD-1:0]       level;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    ovf;
  logic                    udf;

  // Explicit wrap keeps non-power-of-two depths addressing only valid entries.
  function automatic logic [FIFO_ADDR_WD-1:0] next_ptr(input logic [FIFO_ADDR_WD-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
  endfunction

  assign wr_full_o   = (level == DEPTH_LVL);
  assign rd_empty_o  = (level == '0);
  assign wr_afull_o  = (level >= AFULL_LVL);
  assign rd_aempty_o = (level <= AEMPTY_LVL);
  assign level_o     = level;
  assign ovf_o       = ovf;
  assign udf_o       = udf;

  assign wr_acc = wr_en_i && !wr_full_o && !clr_i;
  assign rd_acc = rd_en_i && !rd_empty_o && !clr_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (wr_en_i && wr_full_o) ovf <= 1'b1;
      if (rd_en_i && rd_empty_o) udf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_dat_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_dat_o = rd_empty_o ? '0 : mem[rd_ptr];
`else
  logic [FIFO_DAT_WD-1:0] rd_dat_q;

  // Holds the last popped word; a flush deliberately leaves it untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_dat_q <= '0;
    end else if (rd_acc) begin
      rd_dat_q <= mem[rd_ptr];
    end
  end

  assign rd_dat_o = rd_dat_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: depth-8 default instance plus a depth-5 instance for wrap tests.
// Works in both registered-read and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       clr0 = 0, wr0 = 0, rd0 = 0, clr1 = 0, wr1 = 0, rd1 = 0;
  logic [3:0] wd0 = 0, wd1 = 0, rdd0, rdd1;
  logic       full0, afull0, empty0, aempty0, ovf0, udf0;
  logic       full1, afull1, empty1, aempty1, ovf1, udf1;
  logic [3:0] level0, level1;

  sync_fifo_param dut0 (
    .clk(clk), .rstn(rstn), .clr_i(clr0), .wr_en_i(wr0), .wr_dat_i(wd0),
    .wr_full_o(full0), .wr_afull_o(afull0), .rd_en_i(rd0), .rd_dat_o(rdd0),
    .rd_empty_o(empty0), .rd_aempty_o(aempty0), .level_o(level0), .ovf_o(ovf0), .udf_o(udf0)
  );

  sync_fifo_param #(
    .FIFO_DEPTH(5), .FIFO_DAT_WD(4), .FIFO_ADDR_WD(3), .AFULL_THR(4), .AEMPTY_THR(1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .clr_i(clr1), .wr_en_i(wr1), .wr_dat_i(wd1),
    .wr_full_o(full1), .wr_afull_o(afull1), .rd_en_i(rd1), .rd_dat_o(rdd1),
    .rd_empty_o(empty1), .rd_aempty_o(aempty1), .level_o(level1), .ovf_o(ovf1), .udf_o(udf1)
  );

  int nCompared = 0;
  int nMismatch = 0;

  int depthM [2] = '{8, 5};
  int afullM [2] = '{6, 4};
  int aemptyM[2] = '{2, 1};

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic       movf[2];
  logic       mudf[2];
  logic [3:0] mrd [2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input int s);
    int         sz;
    logic [3:0] head;
    logic [3:0] l, d;
    logic       f, af, e, ae, o, u;
    string      p;
    p = $sformatf("d%0d", s);
    if (s == 0) begin
      sz = q0.size(); head = (sz > 0) ? q0[0] : 4'h0;
      l = level0; d = rdd0; f = full0; af = afull0; e = empty0; ae = aempty0; o = ovf0; u = udf0;
    end else begin
      sz = q1.size(); head = (sz > 0) ? q1[0] : 4'h0;
      l = level1; d = rdd1; f = full1; af = afull1; e = empty1; ae = aempty1; o = ovf1; u = udf1;
    end
    checkOutput({p, " level"},  32'(l),  32'(sz));
    checkOutput({p, " full"},   32'(f),  32'(sz == depthM[s]));
    checkOutput({p, " empty"},  32'(e),  32'(sz == 0));
    checkOutput({p, " afull"},  32'(af), 32'(sz >= afullM[s]));
    checkOutput({p, " aempty"}, 32'(ae), 32'(sz <= aemptyM[s]));
    checkOutput({p, " ovf"},    32'(o),  32'(movf[s]));
    checkOutput({p, " udf"},    32'(u),  32'(mudf[s]));
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput({p, " rd_dat"}, 32'(d),  32'(head));
`else
    checkOutput({p, " rd_dat"}, 32'(d),  32'(mrd[s]));
`endif
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      movf[i] = 1'b0;
      mudf[i] = 1'b0;
      mrd[i]  = 4'h0;
    end
  endtask

  // Drives one cycle on the selected instance, then advances the scoreboard from pre-edge model state.
  task automatic applyStimulus(input int s, input logic w, input logic [3:0] d, input logic r, input logic c);
    int  lv;
    bit  wacc, racc;
    lv = (s == 0) ? q0.size() : q1.size();
    if (s == 0) begin wr0 = w; wd0 = d; rd0 = r; clr0 = c; end
    else        begin wr1 = w; wd1 = d; rd1 = r; clr1 = c; end
    @(posedge clk);
    #1;
    wr0 = 0; rd0 = 0; clr0 = 0; wr1 = 0; rd1 = 0; clr1 = 0;
    if (c) begin
      if (s == 0) q0.delete(); else q1.delete();
      movf[s] = 1'b0;
      mudf[s] = 1'b0;
    end else begin
      wacc = w && (lv < depthM[s]);
      racc = r && (lv > 0);
      if (w && !wacc) movf[s] = 1'b1;
      if (r && !racc) mudf[s] = 1'b1;
      if (racc) mrd[s] = (s == 0) ? q0.pop_front() : q1.pop_front();
      if (wacc) begin
        if (s == 0) q0.push_back(d); else q1.push_back(d);
      end
    end
    checkAll(s);
  endtask

  // Reset is applied between clock edges to exercise its asynchronous path.
  task automatic asyncReset();
    #2;
    rstn = 1'b0;
    #1;
    modelReset();
    checkAll(0);
    checkAll(1);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int nw;
    logic w, r;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    asyncReset();

    for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 4'(i), 0, 0);
    applyStimulus(0, 1, 4'h9, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 4'h0, 1, 0);

    applyStimulus(0, 0, 4'h0, 0, 1);
    applyStimulus(0, 1, 4'hA, 1, 0);
    applyStimulus(0, 1, 4'hB, 0, 0);
    applyStimulus(0, 1, 4'hC, 0, 0);
    applyStimulus(0, 1, 4'hD, 1, 0);
    applyStimulus(0, 1, 4'hE, 1, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 4'(i), 0, 0);
    applyStimulus(0, 1, 4'hF, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'h0, 1, 0);

    applyStimulus(0, 1, 4'h7, 1, 1);
    applyStimulus(0, 1, 4'h6, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0);
    applyStimulus(0, 0, 4'h0, 0, 0);

    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 4'(i), 0, 0);
    asyncReset();
    applyStimulus(0, 1, 4'h9, 0, 0);
    applyStimulus(0, 1, 4'hA, 0, 0);
    applyStimulus(0, 1, 4'hB, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'h0, 1, 0);

    nw = 0;
    for (int i = 0; i < 400 && (nw < 20 || q1.size() > 0); i++) begin
      w = (nw < 20) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      if (w && q1.size() < 5) nw++;
      applyStimulus(1, w, 4'(nw), r, 0);
      checkOutput("d1 level_bound", 32'(level1 > 4'd5), 32'd0);
    end
    if (nw < 20 || q1.size() > 0) checkOutput("d1 stream_timeout", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
